// File: rtl/cmd_sequencer.sv
// Command sequencer: latches a received command, starts the selected task FSM,
// waits for completion and reports ACK/NAK/TMO over the UART. Optional macro: CMD_SEQ_TIMEOUT_EN.
module cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter logic [7:0]  ACK_BYTE    = 8'h06,
   parameter logic [7:0]  NAK_BYTE    = 8'h15,
   parameter logic [7:0]  TMO_BYTE    = 8'h18
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_i,
   output logic [7:0] cmd_o,
   output logic       start_o,
   input  logic       done_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   input  logic       tx_done_i,
   output logic       busy_o,
   output logic       drop_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_START, S_WAIT, S_ACK, S_ACK_WAIT
   } state_e;

   typedef enum logic [1:0] {STS_ACK, STS_NAK, STS_TMO} sts_e;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32'h00FF_FFFF) begin : g_bad_timeout
      $error("cmd_sequencer: TIMEOUT_CYC out of range 2..2^24-1");
   end

   state_e     state_q, state_d;
   sts_e       sts_q, sts_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;
   logic       start_q, start_d;
   logic       drop_q, drop_d;
   logic [7:0] sts_byte;

`ifdef CMD_SEQ_TIMEOUT_EN
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);
   logic [23:0] cnt_q, cnt_d;
`endif

   always_comb begin
      sts_byte = ACK_BYTE;
      case (sts_q)
         STS_NAK: sts_byte = NAK_BYTE;
         STS_TMO: sts_byte = TMO_BYTE;
         default: sts_byte = ACK_BYTE;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      sts_d      = sts_q;
      cmd_d      = cmd_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      start_d    = 1'b0;
      // Any byte arriving outside IDLE is thrown away; cmd_o is untouched.
      drop_d     = rx_done_i && (state_q != S_IDLE);
`ifdef CMD_SEQ_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_done_i) begin
               cmd_d   = rx_data_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (cmd_q)
               8'h01, 8'h02: begin
                  start_d = 1'b1;
                  state_d = S_START;
               end
               8'h00: begin
                  sts_d   = STS_ACK;
                  state_d = S_ACK;
               end
               default: begin
                  sts_d   = STS_NAK;
                  cmd_d   = 8'h00;
                  state_d = S_ACK;
               end
            endcase
         end
         S_START: begin
`ifdef CMD_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done_i takes priority over an expiring timeout in the same cycle.
            if (done_i) begin
               sts_d   = STS_ACK;
               state_d = S_ACK;
            end
`ifdef CMD_SEQ_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               sts_d   = STS_TMO;
               cmd_d   = 8'h00;
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
`endif
         end
         S_ACK: begin
            tx_data_d  = sts_byte;
            tx_start_d = 1'b1;
            state_d    = S_ACK_WAIT;
         end
         S_ACK_WAIT: begin
            if (tx_done_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         sts_q      <= STS_ACK;
         cmd_q      <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         start_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sts_q      <= sts_d;
         cmd_q      <= cmd_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         start_q    <= start_d;
         drop_q     <= drop_d;
      end
   end

`ifdef CMD_SEQ_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`endif

   assign cmd_o      = cmd_q;
   assign start_o    = start_q;
   assign tx_data_o  = tx_data_q;
   assign tx_start_o = tx_start_q;
   assign drop_o     = drop_q;
   assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer; timeout expectations follow CMD_SEQ_TIMEOUT_EN.
module tb_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] cmd, tx_data;
   logic       start, tx_start, busy, drop;

   int n_cmp = 0;
   int n_bad = 0;
   int n_tx  = 0;
   int n_st  = 0;

   cmd_sequencer #(.TIMEOUT_CYC(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .rx_data_i(rx_data), .rx_done_i(rx_done),
      .cmd_o(cmd), .start_o(start), .done_i(done),
      .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_done_i(tx_done),
      .busy_o(busy), .drop_o(drop)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_start) n_tx++;
      if (start)    n_st++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // After tick we are 1ns into the next cycle.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse rx_done for the current cycle; returns in the following cycle.
   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic tx_ack();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   int tx0, st0;

   initial begin
      #2;
      chk("rst_cmd", cmd, 8'h00);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_start", start, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_drop", drop, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // cmd 01: start at +2, done at +10 -> tx_start at +12
      send(8'h01);                              // cycle 1
      chk("c01_cmd", cmd, 8'h01);
      chk("c01_start_early", start, 0);
      tick();                                   // cycle 2
      chk("c01_start", start, 1);
      chk("c01_busy", busy, 1);
      tick();                                   // cycle 3
      chk("c01_start_once", start, 0);
      tick(7);                                  // cycle 10
      done = 1'b1;
      tick();                                   // cycle 11
      done = 1'b0;
      chk("c01_tx_start_early", tx_start, 0);
      tick();                                   // cycle 12
      chk("c01_tx_start", tx_start, 1);
      chk("c01_tx_data", tx_data, 8'h06);
      tick();                                   // cycle 13
      chk("c01_tx_start_once", tx_start, 0);
      chk("c01_busy_ackwait", busy, 1);
      chk("c01_tx_hold", tx_data, 8'h06);
      tx_ack();
      chk("c01_idle", busy, 0);

      // NOP and invalid command
      st0 = n_st;
      send(8'h00);
      tick(2);
      chk("nop_tx_start", tx_start, 1);
      chk("nop_tx_data", tx_data, 8'h06);
      chk("nop_no_start", n_st, st0);
      tx_ack();
      send(8'h7F);
      chk("inv_cmd_latched", cmd, 8'h7F);
      tick();
      chk("inv_cmd_cleared", cmd, 8'h00);
      tick();
      chk("inv_tx_start", tx_start, 1);
      chk("inv_tx_data", tx_data, 8'h15);
      tx_ack();
      chk("inv_idle", busy, 0);

      // byte during WAIT is dropped
      tx0 = n_tx;
      send(8'h02);                              // cycle 1
      tick(3);                                  // cycle 4 (WAIT)
      send(8'h01);                              // cycle 5
      chk("drp_pulse", drop, 1);
      chk("drp_cmd", cmd, 8'h02);
      tick();
      chk("drp_once", drop, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick(2);
      tx_ack();
      tick(3);
      chk("drp_one_ack", n_tx - tx0, 1);
      chk("drp_cmd_end", cmd, 8'h02);
      chk("drp_idle", busy, 0);

      // timeout behaviour
      tx0 = n_tx;
      send(8'h02);                              // cycle 1
`ifdef CMD_SEQ_TIMEOUT_EN
      tick(17);                                 // cycle 18: cnt 15 in WAIT
      chk("tmo_not_yet", n_tx - tx0, 0);
      chk("tmo_cmd_held", cmd, 8'h02);
      tick();                                   // cycle 19: ACK
      chk("tmo_cmd_park", cmd, 8'h00);
      tick();                                   // cycle 20
      chk("tmo_tx_start", tx_start, 1);
      chk("tmo_tx_data", tx_data, 8'h18);
      tx_ack();
      chk("tmo_idle", busy, 0);
`else
      tick(60);
      chk("notmo_busy", busy, 1);
      chk("notmo_no_tx", n_tx - tx0, 0);
      chk("notmo_cmd", cmd, 8'h02);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick(2);
      chk("notmo_tx_data", tx_data, 8'h06);
      tx_ack();
      chk("notmo_idle", busy, 0);
`endif

      // async reset in ACK_WAIT
      send(8'h00);                              // cycle 1
      tick(2);                                  // cycle 3: ACK_WAIT, tx_start high
      chk("ar_pre_tx_start", tx_start, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_tx_start", tx_start, 0);
      chk("ar_busy", busy, 0);
      chk("ar_tx_data", tx_data, 8'h00);
      chk("ar_cmd", cmd, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tx0 = n_tx;
      tick(10);
      chk("ar_no_tx", n_tx - tx0, 0);
      chk("ar_still_idle", busy, 0);
      send(8'h01);
      chk("ar_new_cmd", cmd, 8'h01);
      tick();
      chk("ar_new_start", start, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
